// File: rtl/z180_dma_pkg.sv
// Shared definitions for the Z8S180 bus-master DMA block.
//
// Contents:
//   ADDR_W           Z180 physical address width.
//   CYCLES_PER_BYTE  phi cycles per copied byte once the bus is granted.
//   dma_state_t      state encoding shared by the controller and the bus-cycle sequencer.
//                    The bus-cycle sequencer reuses IDLE to mean "not driving the bus".
//   is_bus_phase()   true for RD1..WR3, the states in which the block drives the bus.
package z180_dma_pkg;

    localparam int ADDR_W          = 20;
    localparam int CYCLES_PER_BYTE = 6;

    typedef logic [3:0] dma_state_t;

    localparam dma_state_t IDLE = 4'd0;
    localparam dma_state_t REQ  = 4'd1;
    localparam dma_state_t RD1  = 4'd2;
    localparam dma_state_t RD2  = 4'd3;
    localparam dma_state_t RD3  = 4'd4;
    localparam dma_state_t WR1  = 4'd5;
    localparam dma_state_t WR2  = 4'd6;
    localparam dma_state_t WR3  = 4'd7;
    localparam dma_state_t REL  = 4'd8;
    localparam dma_state_t FIN  = 4'd9;

    // RD1..WR3 are consecutive codes, so a range test is enough.
    function automatic logic is_bus_phase(input dma_state_t s);
        return (s >= RD1) && (s <= WR3);
    endfunction

endpackage

// File: rtl/z180_bus_cycle.sv
// Memory read/write cycle sequencer for the DMA master.
// It runs RD1..RD3 or WR1..WR3 with registered, glitch-free strobes.
//
// Ports:
//   phi, reset_n     clock and asynchronous active-low reset.
//   start            launch a cycle at the next edge. is_write selects WR1 or RD1.
//                    A new cycle may be launched from RD3/WR3, so there is no idle gap between cycles.
//   abort            drop the bus at the next edge, overriding start.
//   addr, wdata      address latched at start. wdata is loaded into the data register
//                    when a write cycle starts, unless a read is completing in RD3.
//   d_in             bus data. It is captured at the end of RD3.
//   rdata            data register. It also drives the write data.
//   cycle_done       high in RD3 and WR3, the last phase of a cycle.
//   a_out, a_oe, d_oe, mreq_n, rd_n, wr_n   bus outputs, all registered.
module z180_bus_cycle
    import z180_dma_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic          phi,
    input  logic          reset_n,
    input  logic          start,
    input  logic          is_write,
    input  logic          abort,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    input  logic [7:0]    d_in,
    output logic [7:0]    rdata,
    output logic          cycle_done,
    output logic [AW-1:0] a_out,
    output logic          a_oe,
    output logic          d_oe,
    output logic          mreq_n,
    output logic          rd_n,
    output logic          wr_n
);

    dma_state_t phase;
    dma_state_t phase_nxt;

    always_comb begin
        phase_nxt = IDLE;
        if (abort) begin
            phase_nxt = IDLE;
        end else if (start) begin
            phase_nxt = is_write ? WR1 : RD1;
        end else begin
            case (phase)
                RD1:     phase_nxt = RD2;
                RD2:     phase_nxt = RD3;
                WR1:     phase_nxt = WR2;
                WR2:     phase_nxt = WR3;
                default: phase_nxt = IDLE;
            endcase
        end
    end

    assign cycle_done = (phase == RD3) || (phase == WR3);

    // Strobes are flops loaded from the next phase.
    // Their values therefore always match the current phase, and no combinational decode reaches the pins.
    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= IDLE;
            a_out  <= '0;
            a_oe   <= 1'b0;
            d_oe   <= 1'b0;
            mreq_n <= 1'b1;
            rd_n   <= 1'b1;
            wr_n   <= 1'b1;
            rdata  <= 8'h00;
        end else begin
            phase  <= phase_nxt;
            a_oe   <= (phase_nxt != IDLE);
            mreq_n <= !((phase_nxt >= RD1) && (phase_nxt <= WR2));
            rd_n   <= !((phase_nxt >= RD1) && (phase_nxt <= RD3));
            wr_n   <= (phase_nxt != WR2);
            d_oe   <= (phase_nxt >= WR1) && (phase_nxt <= WR3);
            if (start && !abort) begin
                a_out <= addr;
            end
            if (phase == RD3 && !abort) begin
                rdata <= d_in;
            end else if (start && is_write && !abort) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/z180_dma_master.sv
// Z8S180 bus-master block copier.
// It requests the bus with busreq_n and waits for busack_n.
// It then copies cmd_len bytes from cmd_src to cmd_dst, taking at most MAX_BURST bytes per bus tenure.
//
// Optional build macro DMA_FILL_EN adds cmd_fill. With cmd_fill = 1, the block writes
// cmd_src[7:0] to every destination byte and skips the read cycle.
//
// Ports:
//   phi, reset_n            clock and asynchronous active-low reset.
//   cmd_valid / cmd_ready   command handshake. The command transfers on a cycle where both are high.
//                           cmd_ready is high only in IDLE, so commands offered while busy wait.
//   cmd_src, cmd_dst, cmd_len (cmd_fill)   command fields, latched at accept. A length of 0 is a no-op.
//   busy, done              busy is high outside IDLE. done is a one-cycle completion pulse.
//   busreq_n, busack_n      bus arbitration with the CPU. busreq_n is registered.
//   a_out/a_oe, d_in, d_out/d_oe, mreq_n, rd_n, wr_n   bus side.
//                           The strobes are meaningful only while a_oe is high.
//   state                   current controller state, for debug.
module z180_dma_master
    import z180_dma_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int ADDR_W    = 20
) (
    input  logic              phi,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [15:0]       cmd_len,
`ifdef DMA_FILL_EN
    input  logic              cmd_fill,
`endif
    output logic              busy,
    output logic              done,
    output logic              busreq_n,
    input  logic              busack_n,
    output logic [ADDR_W-1:0] a_out,
    output logic              a_oe,
    input  logic [7:0]        d_in,
    output logic [7:0]        d_out,
    output logic              d_oe,
    output logic              mreq_n,
    output logic              rd_n,
    output logic              wr_n,
    output dma_state_t        state
);

    logic              fill_in;
`ifdef DMA_FILL_EN
    assign fill_in = cmd_fill;
`else
    assign fill_in = 1'b0;
`endif

    dma_state_t        state_nxt;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [15:0]       remaining;
    logic [16:0]       burst_cnt;
    logic              fill_q;

    logic              accept;
    logic              abort;
    logic              byte_end;
    logic [15:0]       rem_dec;
    logic              last_byte;
    logic [16:0]       burst_inc;
    logic              burst_full;
    logic [ADDR_W-1:0] src_inc;
    logic [ADDR_W-1:0] dst_inc;

    logic              cyc_start;
    logic              cyc_write;
    logic [ADDR_W-1:0] cyc_addr;
    logic [7:0]        cyc_wdata;
    logic              cycle_done;

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = cmd_valid && cmd_ready;
    // The CPU taking the bus back inside a cycle is a protocol violation.
    // Drop the bus, and repeat the byte after the next grant.
    assign abort      = is_bus_phase(state) && busack_n;
    assign byte_end   = (state == WR3) && cycle_done && !abort;
    assign rem_dec    = remaining - 16'd1;
    assign last_byte  = (rem_dec == 16'd0);
    assign burst_inc  = burst_cnt + 17'd1;
    assign burst_full = (burst_inc >= 17'(MAX_BURST));
    // In fill mode src holds the fill byte, so it is not advanced.
    assign src_inc    = fill_q ? src : src + ADDR_W'(1);
    assign dst_inc    = dst + ADDR_W'(1);
    assign cyc_wdata  = fill_q ? src[7:0] : d_out;

    // Cycle launch. The launch for a byte is issued in the cycle before RD1/WR1 starts:
    // from REQ on grant, from RD3 for the write half, and from WR3 for the next byte.
    // This gives back-to-back cycles with no gap.
    always_comb begin
        cyc_start = 1'b0;
        cyc_write = fill_q;
        cyc_addr  = fill_q ? dst : src;
        case (state)
            REQ: begin
                cyc_start = !busack_n;
            end
            RD3: begin
                cyc_start = !busack_n;
                cyc_write = 1'b1;
                cyc_addr  = dst;
            end
            WR3: begin
                cyc_start = !busack_n && !last_byte && !burst_full;
                cyc_addr  = fill_q ? dst_inc : src_inc;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = REQ;
        end else begin
            case (state)
                IDLE: if (accept && cmd_len != 16'd0) state_nxt = REQ;
                REQ:  if (!busack_n) state_nxt = fill_q ? WR1 : RD1;
                RD1:  state_nxt = RD2;
                RD2:  state_nxt = RD3;
                RD3:  if (cycle_done) state_nxt = WR1;
                WR1:  state_nxt = WR2;
                WR2:  state_nxt = WR3;
                WR3: begin
                    if (last_byte)       state_nxt = FIN;
                    else if (burst_full) state_nxt = REL;
                    else                 state_nxt = fill_q ? WR1 : RD1;
                end
                REL:  if (busack_n) state_nxt = REQ;
                FIN:  if (busack_n) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busreq_n  <= 1'b1;
            done      <= 1'b0;
            src       <= '0;
            dst       <= '0;
            remaining <= 16'd0;
            burst_cnt <= 17'd0;
            fill_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            // The request is held through REQ and the whole tenure, including a regrant after an abort.
            busreq_n <= !((state_nxt == REQ) || is_bus_phase(state_nxt));
            done     <= (state == IDLE && accept && cmd_len == 16'd0) ||
                        (state == FIN && busack_n);
            if (accept) begin
                src       <= cmd_src;
                dst       <= cmd_dst;
                remaining <= cmd_len;
                fill_q    <= fill_in;
                burst_cnt <= 17'd0;
            end else if (byte_end) begin
                src       <= src_inc;
                dst       <= dst_inc;
                remaining <= rem_dec;
                burst_cnt <= burst_full ? 17'd0 : burst_inc;
            end else if (state == REL) begin
                burst_cnt <= 17'd0;
            end
        end
    end

    z180_bus_cycle #(
        .AW (ADDR_W)
    ) u_bus_cycle (
        .phi        (phi),
        .reset_n    (reset_n),
        .start      (cyc_start),
        .is_write   (cyc_write),
        .abort      (abort),
        .addr       (cyc_addr),
        .wdata      (cyc_wdata),
        .d_in       (d_in),
        .rdata      (d_out),
        .cycle_done (cycle_done),
        .a_out      (a_out),
        .a_oe       (a_oe),
        .d_oe       (d_oe),
        .mreq_n     (mreq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n)
    );

endmodule

// File: doc/z180_dma_master.md
Name: z180_dma_master

Overview:
- Bus-initiator counterpart to the FPGA's existing CPU-slave decode logic.
- Takes the Z8S180 bus with /BUSREQ and /BUSACK, then runs its own memory read and write cycles to copy a block of SRAM.
- Sits in top beside the VDP. It is programmed by a CPU-side register block through a valid/ready command handshake.
- Top muxes its address, data and strobe outputs onto the shared bus pins only while it owns the bus.

Parameters:
- MAX_BURST, 16: bytes moved per bus tenure before the bus is released to the CPU. Range 1..65535.
- ADDR_W, 20: address width (Z180 physical address).

Ports:
- phi  in  1  CPU PHI clock; all logic is on posedge phi.
- reset_n  in  1  asynchronous reset, active low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_src  in  20  source address.
- cmd_dst  in  20  destination address.
- cmd_len  in  16  byte count. 0 means no-op.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- busreq_n  out  1  bus request to the CPU.
- busack_n  in  1  bus grant from the CPU, synchronous to phi.
- a_out  out  20  address to drive onto the bus.
- a_oe  out  1  top drives a[] from a_out when high.
- d_in  in  8  data bus input.
- d_out  out  8  write data.
- d_oe  out  1  top drives d[] from d_out when high.
- mreq_n, rd_n, wr_n  out  1 each  bus strobes. They are valid only while a_oe is high.

Behaviour:
- Reset is asynchronous and immediate, valid mid-operation:
  - state = IDLE; busreq_n = 1; a_oe = 0; d_oe = 0; mreq_n = rd_n = wr_n = 1; done = 0.
  - src, dst and remaining count are cleared.
  - Any cycle in progress is abandoned, with no partial write strobe.
- IDLE:
  - cmd_valid && cmd_ready accepts the command.
  - src, dst and len are latched.
  - If len == 0: done pulses the next cycle and the state stays IDLE. The bus is never requested.
  - Otherwise go to REQ.
- REQ: busreq_n = 0. Wait until busack_n is sampled low, then go to RD1.
- Read cycle:
  - RD1: a_oe = 1, a_out = src, mreq_n = 0, rd_n = 0.
  - RD2: hold all signals.
  - RD3: hold. At the end of RD3 (posedge), d_in is captured into the data register.
- Write cycle:
  - WR1: a_out = dst, rd_n = 1, mreq_n = 0, d_oe = 1, d_out = data register.
  - WR2: wr_n = 0.
  - WR3: wr_n = 1, mreq_n = 1; d_oe stays high for hold time. At the end of WR3, src and dst are incremented modulo 2^20 and remaining is decremented.
  - WR3 exits to one of three states:
    - RD1 when remaining != 0 and burst count < MAX_BURST.
    - REL when burst count reaches MAX_BURST with bytes remaining.
    - FIN when remaining == 0.
- Strobes are registered and glitch-free. rd_n and wr_n are never low in the same cycle.
- Timing: 6 phi cycles per byte after the grant.
- REL:
  - a_oe = 0, d_oe = 0, strobes high, busreq_n = 1. Burst count is cleared.
  - Wait until busack_n is sampled high, then go to REQ. This guarantees the CPU gets at least one cycle.
- FIN:
  - Same release as REL. When busack_n is high: done = 1 for one cycle, then IDLE.
- Grant withdrawn mid-cycle: if busack_n is sampled high while a bus cycle is in progress, that is a protocol violation by the CPU.
  - The block stops driving immediately.
  - It redoes the current byte from RD1 after the next grant.
  - src, dst and count are not advanced.
- cmd_valid while busy: ignored, because cmd_ready is 0.
- The busreq_n output is registered.

Optional Feature:
- Macro DMA_FILL_EN adds input cmd_fill (1 bit), latched at command accept.
- With the macro and cmd_fill = 1:
  - The read phase is skipped. Each byte runs WR1..WR3 only, 3 cycles per byte.
  - d_out = cmd_src[7:0], latched at accept. src does not increment.
- Without the macro:
  - The port does not exist and only copy mode exists.

Decomposition:
- Package z180_dma_pkg holds:
  - the state enum: IDLE, REQ, RD1, RD2, RD3, WR1, WR2, WR3, REL, FIN;
  - ADDR_W;
  - localparam CYCLES_PER_BYTE = 6.
- One sub-module, z180_bus_cycle, is natural. It owns the RD1..WR3 strobe sequencing and is given addr, wdata, is_write and start; it returns rdata and a cycle_done signal.
- The parent keeps the arbitration, counters and command handshake.

Test Plan:
- Copy src = 0x01000, dst = 0x02000, len = 4 with MAX_BURST = 16:
  - one busreq_n low tenure;
  - 4 reads then 4 writes, interleaved read/write;
  - memory model dst == src;
  - done pulses once;
  - done arrives exactly 24 phi cycles after busack_n is sampled low, plus the FIN release.
- len = 0: done pulses 1 cycle after accept, and busreq_n never goes low.
- len = 40 with MAX_BURST = 16:
  - three tenures of 16, 16 and 8 bytes;
  - busreq_n high for at least 1 cycle between tenures, each waiting for busack_n high;
  - final memory is correct.
- Address wrap, src = 0xFFFFE, len = 4: reads hit 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- reset_n low during WR1:
  - all outputs go to reset values asynchronously within the same cycle;
  - wr_n never goes low;
  - after release, a new command runs normally.
- With DMA_FILL_EN, cmd_fill = 1, src = 0x0A5, dst = 0x03000, len = 8:
  - 8 writes of 0xA5 to 0x03000..0x03007;
  - rd_n is never low;
  - 3 cycles per byte.
